// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and counter sizing.
// Imported by the interface users and the top-level controller.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width: $clog2 of the operand width, never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the bit-serial adder.
// The requester drives start/a/b; the adder returns busy/done/sum/cout.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  sum,
        input  cout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output sum,
        output cout
    );

endinterface

// File: rtl/serial_add_ctrl_ha_cell.sv
// Half-adder cell; two of these plus a carry register form one serial full-add slice.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial LSB-first adder: one bit per clock through two half-adder cells and a carry FF,
// with the result and carry-out registered and held until the next completion.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;

    logic             s1_s;
    logic             c1_s;
    logic             s_s;
    logic             c2_s;
    logic             carry_next_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_bit_s;

    ha_cell u_ha1 (
        .a (sa_r[0]),
        .b (sb_r[0]),
        .s (s1_s),
        .c (c1_s)
    );

    ha_cell u_ha2 (
        .a (s1_s),
        .b (carry_r),
        .s (s_s),
        .c (c2_s)
    );

    // Full-add slice results and the shifted result word for this bit.
    always_comb begin
        carry_next_s = c1_s | c2_s;
        res_next_s   = {s_s, res_r[WIDTH-1:1]};
        last_bit_s   = (cnt_r == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // busy/done registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
        end
    end

    // Operand/result shift registers, carry FF, bit counter and held outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_r    <= '0;
            sb_r    <= '0;
            res_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            carry_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        sa_r    <= bus.a;
                        sb_r    <= bus.b;
                        carry_r <= 1'b0;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                ST_RUN: begin
                    sa_r    <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r    <= {1'b0, sb_r[WIDTH-1:1]};
                    carry_r <= carry_next_s;
                    res_r   <= res_next_s;
                    // The counter is parked at zero on the final bit so it never wraps.
                    if (last_bit_s) begin
                        cnt_r  <= CNT_ZERO;
                        sum_r  <= res_next_s;
                        cout_r <= carry_next_s;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: table vectors, RUN-time corner sequences,
// random back-to-back adds against a+b, and a WIDTH=2 instance.
module tb_serial_add_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [7:0] prev_sum;
    logic       prev_cout;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(2)) bus2 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full add: start accepted at edge k, done visible after edge k+8, idle after k+9.
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob,
                          input logic [7:0] exp_sum, input logic exp_cout, input bit inject);
        bus8.a     = oa;
        bus8.b     = ob;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        check("busy_after_start", {31'd0, bus8.busy}, 32'd1);
        check("done_after_start", {31'd0, bus8.done}, 32'd0);
        bus8.a = ~oa;
        bus8.b = ob ^ 8'h5A;
        for (int i = 1; i < 8; i++) begin
            bus8.start = (inject && i == 3) ? 1'b1 : 1'b0;
            tick();
            check("busy_run", {31'd0, bus8.busy}, 32'd1);
            check("done_run", {31'd0, bus8.done}, 32'd0);
            check("sum_held_run", {24'd0, bus8.sum}, {24'd0, prev_sum});
            check("cout_held_run", {31'd0, bus8.cout}, {31'd0, prev_cout});
        end
        bus8.start = 1'b0;
        tick();
        check("done_pulse", {31'd0, bus8.done}, 32'd1);
        check("busy_done", {31'd0, bus8.busy}, 32'd1);
        check("sum_result", {24'd0, bus8.sum}, {24'd0, exp_sum});
        check("cout_result", {31'd0, bus8.cout}, {31'd0, exp_cout});
        tick();
        check("done_fall", {31'd0, bus8.done}, 32'd0);
        check("busy_fall", {31'd0, bus8.busy}, 32'd0);
        check("sum_hold_idle", {24'd0, bus8.sum}, {24'd0, exp_sum});
        prev_sum  = exp_sum;
        prev_cout = exp_cout;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] na;
        logic [7:0] nb;
        logic [8:0] model;

        total = 0;
        bad   = 0;
        prev_sum  = 8'h00;
        prev_cout = 1'b0;

        tbl[0] = '{a: 8'h3C, b: 8'h5A, sum: 8'h96, cout: 1'b0};
        tbl[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
        tbl[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};
        tbl[3] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};
        tbl[4] = '{a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1};
        tbl[5] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0};

        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = 8'h00;
        bus8.b     = 8'h00;
        bus2.start = 1'b0;
        bus2.a     = 2'b00;
        bus2.b     = 2'b00;
        #2;
        check("rst_busy", {31'd0, bus8.busy}, 32'd0);
        check("rst_done", {31'd0, bus8.done}, 32'd0);
        check("rst_sum", {24'd0, bus8.sum}, 32'd0);
        check("rst_cout", {31'd0, bus8.cout}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table vectors; the second one also carries a stray start pulse at edge k+3.
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].cout, (i == 1));
        end

        // Asynchronous reset between edges k+4 and k+5 discards the add in progress.
        bus8.a     = 8'hA5;
        bus8.b     = 8'h6B;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus8.busy}, 32'd0);
        check("midrst_done", {31'd0, bus8.done}, 32'd0);
        check("midrst_sum", {24'd0, bus8.sum}, 32'd0);
        check("midrst_cout", {31'd0, bus8.cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_done", {31'd0, bus8.done}, 32'd0);
            check("midrst_idle", {31'd0, bus8.busy}, 32'd0);
        end
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
        run_op(8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

        // start tied high: one accept every WIDTH+2 edges, checked against plain a+b.
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        bus8.a     = ra;
        bus8.b     = rb;
        bus8.start = 1'b1;
        for (int op = 0; op < 5; op++) begin
            tick();
            check("held_accept", {31'd0, bus8.busy}, 32'd1);
            na = 8'($urandom_range(0, 255));
            nb = 8'($urandom_range(0, 255));
            bus8.a = na;
            bus8.b = nb;
            model  = {1'b0, ra} + {1'b0, rb};
            for (int i = 1; i < 8; i++) begin
                tick();
                check("held_no_done", {31'd0, bus8.done}, 32'd0);
            end
            tick();
            check("held_done", {31'd0, bus8.done}, 32'd1);
            check("held_sum", {24'd0, bus8.sum}, {24'd0, model[7:0]});
            check("held_cout", {31'd0, bus8.cout}, {31'd0, model[8]});
            tick();
            check("held_gap_idle", {31'd0, bus8.busy}, 32'd0);
            ra = na;
            rb = nb;
        end
        bus8.start = 1'b0;

        // Minimum-width instance.
        bus2.a     = 2'b11;
        bus2.b     = 2'b01;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        check("w2_busy", {31'd0, bus2.busy}, 32'd1);
        tick();
        check("w2_no_done", {31'd0, bus2.done}, 32'd0);
        tick();
        check("w2_done", {31'd0, bus2.done}, 32'd1);
        check("w2_sum", {30'd0, bus2.sum}, 32'd0);
        check("w2_cout", {31'd0, bus2.cout}, 32'd1);
        tick();
        check("w2_idle", {31'd0, bus2.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
